// File: rtl/mcast_flit_injector_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mcast_flit_injector_if                                               |
// | Request and flit-injection handshake bundle for mcast_flit_injector. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mcast_flit_injector_if #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int FLIT_W = 64
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ROWS*COLS-1:0]   req_targets;
  logic [31:0]            req_payload;
  logic [FLIT_W-1:0]      flit_out;
  logic                   flit_valid;
  logic                   flit_ready;
  logic                   busy;
  logic                   done;
  logic [9:0]             seq_id;

  modport master (
    output req_valid, req_targets, req_payload, flit_ready,
    input  req_ready, flit_out, flit_valid, busy, done, seq_id
  );

  modport slave (
    input  req_valid, req_targets, req_payload, flit_ready,
    output req_ready, flit_out, flit_valid, busy, done, seq_id
  );
endinterface
`default_nettype wire

// File: rtl/mcast_flit_injector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mcast_flit_injector                                                  |
// | Expands a bitmap multicast request into one-hop mesh flits.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mcast_flit_injector #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int FLIT_W = 64,
  parameter int SRC_R  = 0,
  parameter int SRC_C  = 0
) (
  input logic                 clk,
  input logic                 rst,
  mcast_flit_injector_if.slave bus
);
  localparam int N       = ROWS * COLS;
  localparam int SRC_IDX = SRC_R * COLS + SRC_C;
  localparam logic [N-1:0] SRC_BIT = N'(1) << SRC_IDX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      remaining_q, remaining_d;
  logic              pend_local_q, pend_local_d;
  logic [31:0]       payload_q, payload_d;
  logic [9:0]        cur_seq_q, cur_seq_d;
  logic [9:0]        seq_id_q, seq_id_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              flit_valid_q, flit_valid_d;
  logic              done_q, done_d;

  logic              sel_found;
  logic [7:0]        sel_row;
  logic [7:0]        sel_col;
  logic [N-1:0]      sel_onehot;
  logic [4:0]        dir_mask;
  logic [FLIT_W-1:0] flit_body;

  // Lowest set remaining bit gives ascending tile-index emission order.
  always_comb begin
    sel_found  = 1'b0;
    sel_row    = '0;
    sel_col    = '0;
    sel_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (!sel_found && remaining_q[i]) begin
        sel_found     = 1'b1;
        sel_row       = 8'(i / COLS);
        sel_col       = 8'(i % COLS);
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // XY routing: column difference wins over row difference.
  always_comb begin
    dir_mask = 5'b00000;
    if (int'(sel_col) > SRC_C) begin
      dir_mask = 5'b01000;
    end else if (int'(sel_col) < SRC_C) begin
      dir_mask = 5'b00010;
    end else if (int'(sel_row) > SRC_R) begin
      dir_mask = 5'b00100;
    end else if (int'(sel_row) < SRC_R) begin
      dir_mask = 5'b10000;
    end
  end

  always_comb begin
    flit_body        = '0;
    flit_body[63:32] = payload_q;
    flit_body[31]    = 1'b1;
    flit_body[30:26] = sel_found ? (dir_mask | {4'b0000, pend_local_q}) : 5'b00001;
    flit_body[25:16] = cur_seq_q;
    flit_body[15:8]  = sel_found ? sel_row : 8'(SRC_R);
    flit_body[7:0]   = sel_found ? sel_col : 8'(SRC_C);
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    pend_local_d = pend_local_q;
    payload_d    = payload_q;
    cur_seq_d    = cur_seq_q;
    seq_id_d     = seq_id_q;
    flit_d       = flit_q;
    flit_valid_d = flit_valid_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          remaining_d  = bus.req_targets & ~SRC_BIT;
          pend_local_d = |(bus.req_targets & SRC_BIT);
          payload_d    = bus.req_payload;
          cur_seq_d    = seq_id_q;
          seq_id_d     = seq_id_q + 10'd1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (sel_found || pend_local_q) begin
          flit_d       = flit_body;
          flit_valid_d = 1'b1;
          remaining_d  = remaining_q & ~sel_onehot;
          pend_local_d = 1'b0;
          state_d      = SEND;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      SEND: begin
        if (bus.flit_ready) begin
          flit_valid_d = 1'b0;
          if (remaining_q != '0) begin
            state_d = LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      pend_local_q <= 1'b0;
      payload_q    <= '0;
      cur_seq_q    <= '0;
      seq_id_q     <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      pend_local_q <= pend_local_d;
      payload_q    <= payload_d;
      cur_seq_q    <= cur_seq_d;
      seq_id_q     <= seq_id_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      done_q       <= done_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.flit_out   = flit_q;
  assign bus.flit_valid = flit_valid_q;
  assign bus.done       = done_q;
  assign bus.seq_id     = seq_id_q;
endmodule
`default_nettype wire

// File: tb/tb_mcast_flit_injector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mcast_flit_injector                                               |
// | Directed bench with a queue-based flit model for a 2x2 mesh, SRC 0,0.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mcast_flit_injector;
  localparam int ROWS    = 2;
  localparam int COLS    = 2;
  localparam int FLIT_W  = 64;
  localparam int SRC_R   = 0;
  localparam int SRC_C   = 0;
  localparam int N       = ROWS * COLS;
  localparam int SRC_IDX = SRC_R * COLS + SRC_C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcast_flit_injector_if #(.ROWS(ROWS), .COLS(COLS), .FLIT_W(FLIT_W)) bus ();

  mcast_flit_injector #(
    .ROWS(ROWS), .COLS(COLS), .FLIT_W(FLIT_W), .SRC_R(SRC_R), .SRC_C(SRC_C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [63:0] exp_q[$];
  logic [63:0] acc_log[$];
  logic [9:0]  exp_seq = 10'd0;
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, expv);
  endtask

  function automatic logic [4:0] dir_of(int r, int c);
    if (c > SRC_C) return 5'b01000;
    if (c < SRC_C) return 5'b00010;
    if (r > SRC_R) return 5'b00100;
    if (r < SRC_R) return 5'b10000;
    return 5'b00000;
  endfunction

  function automatic logic [63:0] mk(logic [31:0] p, logic [4:0] m, logic [9:0] s, int r, int c);
    return {p, 1'b1, m, s, 8'(r), 8'(c)};
  endfunction

  task automatic model_push(logic [N-1:0] t, logic [31:0] p, logic [9:0] s);
    bit first = 1'b1;
    bit loc   = t[SRC_IDX];
    logic [4:0] m;
    for (int i = 0; i < N; i++) begin
      if (i != SRC_IDX && t[i]) begin
        m = dir_of(i / COLS, i % COLS);
        if (first && loc) m[0] = 1'b1;
        exp_q.push_back(mk(p, m, s, i / COLS, i % COLS));
        first = 1'b0;
      end
    end
    if (first && loc) exp_q.push_back(mk(p, 5'b00001, s, SRC_R, SRC_C));
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("seq_id", 64'(bus.seq_id), 64'(exp_seq));
      if (bus.flit_valid) begin
        chk("flit_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk("flit_out", bus.flit_out, exp_q[0]);
          if (bus.flit_ready) begin
            acc_log.push_back(bus.flit_out);
            void'(exp_q.pop_front());
          end
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_drained", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic send_req(logic [N-1:0] t, logic [31:0] p);
    int k = 0;
    while (bus.req_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("req_ready_wait", 64'(bus.req_ready), 64'd1);
    bus.req_valid   = 1'b1;
    bus.req_targets = t;
    bus.req_payload = p;
    @(posedge clk); #1;
    bus.req_valid   = 1'b0;
    bus.req_targets = '0;
    model_push(t, p, exp_seq);
    exp_seq = exp_seq + 10'd1;
  endtask

  task automatic wait_done(string name, int budget);
    int k = 0;
    while (bus.done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(bus.done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(string name);
    int k = 0;
    @(negedge clk);
    while (bus.flit_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(bus.flit_valid), 64'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_seq = 10'd0;
  endtask

  // Runs one request with flit_ready high and checks the accepted flits literally.
  task automatic run_req(string name, logic [N-1:0] t, logic [31:0] p,
                         int nexp, logic [63:0] f0, logic [63:0] f1, logic [63:0] f2);
    int base = acc_log.size();
    int d0   = done_cnt;
    send_req(t, p);
    wait_done({name, "_done"}, 30);
    repeat (2) begin @(posedge clk); #1; end
    chk({name, "_count"}, 64'(acc_log.size() - base), 64'(nexp));
    chk({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    if (nexp > 0) chk({name, "_f0"}, acc_log[base], f0);
    if (nexp > 1) chk({name, "_f1"}, acc_log[base + 1], f1);
    if (nexp > 2) chk({name, "_f2"}, acc_log[base + 2], f2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int d0;
    logic [63:0] held;

    bus.req_valid   = 1'b0;
    bus.req_targets = '0;
    bus.req_payload = '0;
    bus.flit_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flit_valid", 64'(bus.flit_valid), 64'd0);
    chk("rst_flit_out",   bus.flit_out,         64'd0);
    chk("rst_req_ready",  64'(bus.req_ready),   64'd1);
    chk("rst_busy",       64'(bus.busy),        64'd0);
    chk("rst_done",       64'(bus.done),        64'd0);
    chk("rst_seq_id",     64'(bus.seq_id),      64'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Sequence id wrap: ids 0..1023, then the 1025th request gets 0 again.
    for (int i = 0; i < 1024; i++) begin
      send_req('0, 32'(i));
      wait_done("empty_done", 10);
    end
    chk("wrap_seq_before", 64'(bus.seq_id), 64'd0);
    send_req('0, 32'h0);
    wait_done("wrap_done", 10);
    chk("wrap_seq_after", 64'(bus.seq_id), 64'd1);

    pulse_reset();
    @(negedge clk);
    chk("reset_seq_id", 64'(bus.seq_id), 64'd0);
    @(posedge clk); #1;

    run_req("t0011", 4'b0011, 32'hDEADBEEF, 1, 64'hDEADBEEF_A400_0001, 64'h0, 64'h0);
    run_req("t0101", 4'b0101, 32'h12345678, 1, 64'h12345678_9401_0100, 64'h0, 64'h0);
    run_req("t1110", 4'b1110, 32'hCAFEF00D, 3, 64'hCAFEF00D_A002_0001,
            64'hCAFEF00D_9002_0100, 64'hCAFEF00D_A002_0101);
    run_req("t0001", 4'b0001, 32'h0BADC0DE, 1, 64'h0BADC0DE_8403_0000, 64'h0, 64'h0);

    // Empty request: done two cycles after accept, nothing emitted.
    d0 = done_cnt;
    send_req(4'b0000, 32'h99999999);
    @(negedge clk);
    chk("empty_done_early", 64'(bus.done), 64'd0);
    chk("empty_no_valid1",  64'(bus.flit_valid), 64'd0);
    @(negedge clk);
    chk("empty_done",       64'(bus.done), 64'd1);
    chk("empty_req_ready",  64'(bus.req_ready), 64'd1);
    chk("empty_no_valid2",  64'(bus.flit_valid), 64'd0);
    @(posedge clk); #1;
    chk("empty_done_once", 64'(done_cnt - d0), 64'd1);

    // Backpressure on the second flit of a three-flit request.
    base = acc_log.size();
    bus.flit_ready = 1'b0;
    send_req(4'b1110, 32'h55AA55AA);
    wait_valid("bp_first_valid");
    @(posedge clk); #1;
    bus.flit_ready = 1'b1;
    @(posedge clk); #1;
    bus.flit_ready = 1'b0;
    wait_valid("bp_second_valid");
    held = bus.flit_out;
    chk("bp_held_value", held, 64'h55AA55AA_9005_0100);
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", bus.flit_out, held);
      chk("bp_valid_held", 64'(bus.flit_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus.flit_ready = 1'b1;
    wait_done("bp_done", 30);
    chk("bp_count", 64'(acc_log.size() - base), 64'd3);
    chk("bp_f0", acc_log[base],     64'h55AA55AA_A005_0001);
    chk("bp_f1", acc_log[base + 1], 64'h55AA55AA_9005_0100);
    chk("bp_f2", acc_log[base + 2], 64'h55AA55AA_A005_0101);

    // Reset while the second of three flits is pending.
    bus.flit_ready = 1'b0;
    send_req(4'b1110, 32'h11112222);
    wait_valid("rm_first_valid");
    @(posedge clk); #1;
    bus.flit_ready = 1'b1;
    @(posedge clk); #1;
    bus.flit_ready = 1'b0;
    wait_valid("rm_second_valid");
    d0 = done_cnt;
    @(posedge clk); #1;
    pulse_reset();
    @(negedge clk);
    chk("rm_flit_valid", 64'(bus.flit_valid), 64'd0);
    chk("rm_seq_id",     64'(bus.seq_id),     64'd0);
    chk("rm_busy",       64'(bus.busy),       64'd0);
    chk("rm_no_done",    64'(done_cnt - d0),  64'd0);
    @(posedge clk); #1;
    bus.flit_ready = 1'b1;
    run_req("after_rst", 4'b0110, 32'h77778888, 2, 64'h77778888_A000_0001,
            64'h77778888_9000_0100, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mcast_flit_injector.md
# mcast_flit_injector

Transmit-side companion to the multicast-enabled `router_mesh` ingress. It accepts one delivery request, a payload plus a bitmap of target tiles, and expands it into a sequence of one-hop multicast flits. Each remote target gets its own flit carrying the first-hop direction. Delivery to the source tile's own local port is merged into the first flit's L bit. The block drives the mesh external or tile injection port through a valid/ready handshake.

## Interface
- `ROWS`, 2: mesh rows.
- `COLS`, 2: mesh columns.
- `FLIT_W`, 64: flit width; must be ≥ 64.
- `SRC_R`, 0: row of the tile this injector feeds.
- `SRC_C`, 0: column of the tile this injector feeds.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request offered.
- `req_ready` out 1: block can accept a request (IDLE only).
- `req_targets` in ROWS*COLS: target tile bitmap; tile index = r*COLS + c.
- `req_payload` in 32: payload copied into every flit of the request.
- `flit_out` out FLIT_W: registered flit.
- `flit_valid` out 1: flit offered to the mesh.
- `flit_ready` in 1: mesh accepts the flit.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse when the last flit of a request is accepted, or when an empty request completes.
- `seq_id` out 10: id that will be assigned to the next accepted request.

## Operation
- Flit layout:
  - [63:32] payload.
  - [31] mcast flag = 1.
  - [30:26] mask {N,E,S,W,L} (bit4 = N … bit0 = L).
  - [25:16] sequence id.
  - [15:8] dest row.
  - [7:0] dest col.
  - Bits above 63 are 0.
- Mask direction per remote target (r,c), XY order, X resolved first:
  - c > SRC_C → E, 01000.
  - c < SRC_C → W, 00010.
  - Otherwise r > SRC_R → S, 00100.
  - Otherwise r < SRC_R → N, 10000.
- On request accept:
  - Remaining set = `req_targets` with the source-tile bit cleared.
  - `pend_local` = source-tile bit.
  - Payload and current `seq_id` are latched.
  - `seq_id` increments, 10-bit, wrapping 1023 → 0.
- Flit order is ascending tile index over the remaining set.
- L bit is set only on the first emitted flit, and only when `pend_local` = 1. `pend_local` is then cleared.
- Source-only request: a single flit is emitted with mask 00001 and dest = (SRC_R, SRC_C).
- Empty request (targets == 0): no flit is emitted; `done` pulses.
- States:
  - IDLE: `req_ready` = 1. Handshake → LOAD.
  - LOAD: select the lowest set remaining bit, or the source-only case. Build the flit into the output register, clear the selected bit, set `flit_valid`. → SEND. If nothing is to be sent, → IDLE and pulse `done`.
  - SEND: hold `flit_out` and `flit_valid` until `flit_ready`. On acceptance:
    - Remaining ≠ 0 → LOAD, with `flit_valid` low for one cycle.
    - Remaining = 0 → IDLE, with `done` pulsed in the same cycle.
- Reset values: `flit_valid` = 0, `flit_out` = 0, `req_ready` = 1 once in IDLE, `busy` = 0, `done` = 0, `seq_id` = 0, state = IDLE.

## Timing
- Request accepted at edge E0 (`req_valid` & `req_ready`).
- LOAD occupies the cycle after E0. `flit_valid` rises after edge E1, so the first flit is offered 2 cycles after accept.
- Throughput: one flit per 2 cycles when `flit_ready` is held high. `flit_ready` being high while `flit_valid` is low has no effect.
- Under backpressure, `flit_out` is stable while `flit_valid` = 1 and `flit_ready` = 0. `flit_valid` never drops without a handshake, except on reset.
- `done` is registered: it is high during the cycle following the final acceptance edge, or following LOAD for an empty request.
- `req_ready` is low from E0 until the state returns to IDLE. Back-to-back requests are separated by at least one IDLE cycle.
- `rst` asserted mid-request takes effect at the next edge:
  - The in-flight request is dropped.
  - `flit_valid` = 0.
  - `seq_id` = 0.
  - No `done` pulse.

## Test plan
- 2x2, SRC (0,0), targets 0011, payload 0xDEADBEEF → exactly one flit 0xDEADBEEF_A400_0001: mask 01001, seq 0, dest (0,1). `done` pulses once.
- Targets 0101 → one flit, mask 00101, dest (1,0), seq 1. Targets 1110 → three flits in order:
  - dest (0,1), mask 01000.
  - dest (1,0), mask 00100.
  - dest (1,1), mask 01000.
  - All three carry seq 2 and L = 0.
- Targets 0001 → one flit, mask 00001, dest (0,0). Targets 0000 → no `flit_valid`; `done` asserted 2 cycles after accept; `req_ready` high again.
- Targets 1110 with `flit_ready` held low for 5 cycles on the second flit → `flit_out` is bit-stable for all 5 cycles. Total accepted flits = 3, with no duplicates and no skips.
- 1025 empty requests → the 1025th request is assigned seq 0 (wrap), and `seq_id` reads 1 afterwards.
- `rst` pulsed while the second of three flits is pending → `flit_valid` = 0 on the next cycle, `seq_id` = 0, `busy` = 0. A new request then produces correct flits with seq 0.
